// File: rtl/operand_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_sequencer
// Brief    : Scoreboard hazard check, rs1/rs2 fetch over one shared register
//            file read port, valid/ready hand-off to execute.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [4:0]            in_rd,
    input  logic                  in_uses_rs1,
    input  logic                  in_uses_rs2,
    input  logic                  in_writes_rd,
    input  logic [DATA_WIDTH-1:0] in_immediate,
    output logic [4:0]            rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rs1_value,
    output logic [DATA_WIDTH-1:0] out_rs2_value,
    output logic [4:0]            out_rd,
    output logic                  out_writes_rd,
    output logic [DATA_WIDTH-1:0] out_immediate,
    output logic [NUM_REGS-1:0]   busy_mask
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_HAZARD   = 3'd1;
    localparam logic [2:0] c_READ_RS1 = 3'd2;
    localparam logic [2:0] c_READ_RS2 = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [4:0]            r_rs1;
    logic [4:0]            r_rs2;
    logic [4:0]            r_rd;
    logic                  r_uses_rs1;
    logic                  r_uses_rs2;
    logic                  r_writes_rd;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_rs1_value;
    logic [DATA_WIDTH-1:0] r_rs2_value;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_clr_mask;
    logic                  w_stall;

    // Hazard check sees only the registered scoreboard; a writeback unblocks next cycle.
    assign w_stall = (r_uses_rs1  & r_busy[r_rs1]) |
                     (r_uses_rs2  & r_busy[r_rs2]) |
                     (r_writes_rd & r_busy[r_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:     if (in_valid) w_state_nxt = c_HAZARD;
            c_HAZARD:   if (!w_stall) w_state_nxt = c_READ_RS1;
            c_READ_RS1: w_state_nxt = c_READ_RS2;
            c_READ_RS2: w_state_nxt = c_DONE;
            c_DONE:     if (out_ready) w_state_nxt = c_IDLE;
            default:    w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (r_state == c_IDLE) & ~rst;
        out_valid    = (r_state == c_DONE);
        rf_read_addr = 5'd0;
        case (r_state)
            c_HAZARD:   if (!w_stall) rf_read_addr = r_rs1;
            c_READ_RS1: rf_read_addr = r_rs2;
            default:    rf_read_addr = 5'd0;
        endcase
    end

    // Set and clear are independent masks so that set wins on a shared index.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (r_state == c_READ_RS2 && r_writes_rd && r_rd != 5'd0) begin
            w_set_mask[r_rd] = 1'b1;
        end
        if (wb_valid && wb_rd != 5'd0) begin
            w_clr_mask[wb_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_uses_rs1  <= 1'b0;
            r_uses_rs2  <= 1'b0;
            r_writes_rd <= 1'b0;
            r_imm       <= '0;
            r_rs1_value <= '0;
            r_rs2_value <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_rs1       <= in_rs1;
                        r_rs2       <= in_rs2;
                        r_rd        <= in_rd;
                        r_uses_rs1  <= in_uses_rs1;
                        r_uses_rs2  <= in_uses_rs2;
                        r_writes_rd <= in_writes_rd;
                        r_imm       <= in_immediate;
                    end
                end
                c_READ_RS1: r_rs1_value <= (r_uses_rs1 && r_rs1 != 5'd0) ? rf_read_data : '0;
                c_READ_RS2: r_rs2_value <= (r_uses_rs2 && r_rs2 != 5'd0) ? rf_read_data : '0;
                default: ;
            endcase
        end
    end

    assign out_rs1_value = r_rs1_value;
    assign out_rs2_value = r_rs2_value;
    assign out_rd        = r_rd;
    assign out_writes_rd = r_writes_rd;
    assign out_immediate = r_imm;
    assign busy_mask     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch_sequencer
// Brief    : Directed and random instructions against a transaction-level
//            model of scoreboard, stall length and operand values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_uses_rs1, in_uses_rs2, in_writes_rd;
    logic [31:0] in_immediate;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_value, out_rs2_value, out_immediate;
    logic [4:0]  out_rd;
    logic        out_writes_rd;
    logic [31:0] busy_mask;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rf_mem [32];
    logic [31:0] m_busy;

    operand_fetch_sequencer #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
        .in_immediate(in_immediate),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
        .out_rd(out_rd), .out_writes_rd(out_writes_rd),
        .out_immediate(out_immediate), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    // Synchronous register file: data appears the cycle after the address.
    always @(posedge clk) rf_read_data <= rf_mem[rf_read_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
        tick();
        chk("rst_in_ready_low", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_rf_addr", rf_read_addr, 5'd0);
        chk("rst_out_rs1", out_rs1_value, 32'h0);
        chk("rst_out_rs2", out_rs2_value, 32'h0);
        chk("rst_out_rd", out_rd, 5'd0);
        chk("rst_out_imm", out_immediate, 32'h0);
        m_busy = 32'h0;
    endtask

    // One instruction end to end. Expected stall, operands and scoreboard come
    // from the model: blocking registers are released by writebacks issued one
    // per cycle from wstart, and the hazard check clears the cycle after the last.
    task automatic run_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2, input logic wr,
                             input int wstart, input int bp,
                             input logic coll_en, input logic [4:0] coll_rd);
        logic [4:0]  blk[$];
        logic [5:0]  sched [64];
        logic [31:0] imm, e1, e2, nb;
        int          h;
        imm = $urandom;
        for (int i = 0; i < 64; i++) sched[i] = 6'd0;
        if (u1 && m_busy[rs1]) blk.push_back(rs1);
        if (u2 && m_busy[rs2] && !(u1 && rs2 == rs1)) blk.push_back(rs2);
        if (wr && m_busy[rd] && !(u1 && rd == rs1) && !(u2 && rd == rs2)) blk.push_back(rd);
        h = 1;
        foreach (blk[i]) sched[wstart + i] = {1'b1, blk[i]};
        if (blk.size() > 0) h = wstart + blk.size();
        if (coll_en) sched[h + 2] = {1'b1, coll_rd};
        nb = m_busy;
        foreach (blk[i]) nb[blk[i]] = 1'b0;
        if (coll_en) nb[coll_rd] = 1'b0;
        if (wr && rd != 5'd0) nb[rd] = 1'b1;
        e1 = (u1 && rs1 != 5'd0) ? rf_mem[rs1] : 32'h0;
        e2 = (u2 && rs2 != 5'd0) ? rf_mem[rs2] : 32'h0;

        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_uses_rs1 = u1; in_uses_rs2 = u2; in_writes_rd = wr; in_immediate = imm;
        chk("idle_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < h + 3; c++) begin
            chk("early_out_valid", out_valid, 1'b0);
            chk("busy_in_ready", in_ready, 1'b0);
            chk("rf_read_addr", rf_read_addr, (c == h) ? rs1 : ((c == h + 1) ? rs2 : 5'd0));
            wb_valid = sched[c][5];
            wb_rd    = sched[c][4:0];
            tick();
        end
        wb_valid = 1'b0; wb_rd = 5'd0;
        for (int k = 0; k <= bp; k++) begin
            chk("done_out_valid", out_valid, 1'b1);
            chk("done_in_ready", in_ready, 1'b0);
            chk("out_rs1_value", out_rs1_value, e1);
            chk("out_rs2_value", out_rs2_value, e2);
            chk("out_rd", out_rd, rd);
            chk("out_writes_rd", out_writes_rd, wr);
            chk("out_immediate", out_immediate, imm);
            chk("done_busy", busy_mask, nb);
            out_ready = (k == bp);
            in_valid  = (k < bp);
            in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom);
            in_immediate = $urandom;
            tick();
        end
        out_ready = 1'b0; in_valid = 1'b0;
        chk("post_out_valid", out_valid, 1'b0);
        chk("post_in_ready", in_ready, 1'b1);
        chk("post_busy", busy_mask, nb);
        m_busy = nb;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_writes_rd = 1'b0; in_immediate = 32'h0;
        m_busy = 32'h0;
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hDEAD_BEEF;
        do_reset();

        // Happy path
        rf_mem[3] = 32'h11; rf_mem[5] = 32'h22;
        run_instr(5'd3, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 5'd0);
        chk("happy_busy", busy_mask, 32'h80);

        // RAW stall released by a writeback in cycle 6
        run_instr(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 5'd0);
        run_instr(5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 6, 0, 1'b0, 5'd0);
        chk("raw_busy3", busy_mask[3], 1'b0);

        // x0 and unused source: no stall despite busy[9]
        run_instr(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 5'd0);
        run_instr(5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 5'd0);
        chk("x0_busy0", busy_mask[0], 1'b0);

        // Backpressure with in_valid held during DONE
        run_instr(5'd3, 5'd5, 5'd10, 1'b1, 1'b1, 1'b1, 1, 5, 1'b0, 5'd0);

        // Set/clear collisions
        run_instr(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1, 0, 1'b1, 5'd4);
        chk("coll_same_busy4", busy_mask[4], 1'b1);
        run_instr(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 5'd0);
        run_instr(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 2, 0, 1'b1, 5'd6);
        chk("coll_diff_busy4", busy_mask[4], 1'b1);
        chk("coll_diff_busy6", busy_mask[6], 1'b0);

        // Reset while in READ_RS1 with two registers busy
        do_reset();
        run_instr(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 5'd0);
        run_instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 5'd0);
        chk("pre_rst_busy", busy_mask, 32'h30);
        in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3;
        in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1; in_writes_rd = 1'b1; in_immediate = 32'h1234;
        tick();
        in_valid = 1'b0;
        tick();
        chk("midop_read_rs1_addr", rf_read_addr, 5'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midop_busy", busy_mask, 32'h0);
        chk("midop_out_valid", out_valid, 1'b0);
        chk("midop_in_ready", in_ready, 1'b1);
        chk("midop_out_imm", out_immediate, 32'h0);
        m_busy = 32'h0;

        // Random instructions
        for (int n = 0; n < 40; n++) begin
            for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
            run_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      $urandom_range(1, 4), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
